// File: rtl/mux_pkg.sv
// Shared types for the N:1 scanning multiplexer: the FSM state encoding
// and the two mode-port values.
package mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_n1_comb.sv
// Parametrised combinational N:1 channel select.
// Any index at or beyond N_CH falls through to the last channel, and the
// index actually used is reported on ch_o so the caller can tag the sample.
module mux_n1_comb #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 1,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic [N_CH*DATA_W-1:0] din_i,
    input  logic [SEL_W-1:0]       idx_i,
    output logic [DATA_W-1:0]      dat_o,
    output logic [SEL_W-1:0]       ch_o
);

    // Match idx against every in-range channel; otherwise keep the last-channel default.
    always_comb begin
        ch_o  = SEL_W'(N_CH - 1);
        dat_o = din_i[(N_CH-1)*DATA_W +: DATA_W];
        for (int k = 0; k < N_CH - 1; k++) begin
            if (idx_i == SEL_W'(k)) begin
                ch_o  = SEL_W'(k);
                dat_o = din_i[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mux_n1_scan.sv
// N:1 multiplexer with registered, ready/valid-handshaked output and an
// optional auto-scan channel sequencer.
//
// Build option: define MUX_N1_SCAN_EN to enable auto-scan. Without it the
// mode input is ignored (always manual) and no scan counter exists.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not running; no sample loaded, waiting for en
// RUN   | loading samples whenever the output register is free/accepted;
//       | stays here after en falls until a stalled sample is accepted
module mux_n1_scan
    import mux_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int DATA_W = 1,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] din,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   en,
    input  logic                   mode,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      dout,
    output logic [SEL_W-1:0]       dout_ch,
    output logic                   dout_valid
);

    state_t              state_q, state_d;
    logic                load;
    logic                slot_free;
    logic [SEL_W-1:0]    sel_idx;
    logic [DATA_W-1:0]   mux_dat;
    logic [SEL_W-1:0]    mux_ch;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [SEL_W-1:0]    dout_ch_q, dout_ch_d;
    logic                dout_valid_q, dout_valid_d;

    // Output register can take a new sample: empty, or its sample leaves this cycle.
    assign slot_free = !dout_valid_q || out_ready;

`ifdef MUX_N1_SCAN_EN
    logic [SEL_W-1:0] scan_cnt_q, scan_cnt_d;

    assign sel_idx = (mode == MODE_SCAN) ? scan_cnt_q : sel;

    // Scan pointer advances only when a scan-mode sample is actually loaded.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        if (load && (mode == MODE_SCAN)) begin
            if (scan_cnt_q == SEL_W'(N_CH - 1)) begin
                scan_cnt_d = '0;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end
    end

    // Scan pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
        end
    end
`else
    // Scan disabled: mode has no effect, kept only so the port list is build-independent.
    logic mode_unused;
    assign mode_unused = mode;
    assign sel_idx     = sel;
`endif

    mux_n1_comb #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_comb (
        .din_i (din),
        .idx_i (sel_idx),
        .dat_o (mux_dat),
        .ch_o  (mux_ch)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and load decode; RUN is held while a sample is stalled so it is never lost.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    load = slot_free;
                end else if (slot_free) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register next value: load a new sample, drop an accepted one, else hold.
    always_comb begin
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        if (load) begin
            dout_d       = mux_dat;
            dout_ch_d    = mux_ch;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && out_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // Output register; reset discards any pending sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux_n1_scan.sv
// Bench for mux_n1_scan: an 8-channel and a 6-channel instance (4-bit data)
// share all control inputs. Directed table, scan/stall/reset sequences,
// then randomized traffic against a sample-level reference model.
module tb_mux_n1_scan;

`ifdef MUX_N1_SCAN_EN
    localparam bit SCAN_ON = 1'b1;
`else
    localparam bit SCAN_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic        out_ready;
    logic [2:0]  sel;
    logic [31:0] din8;
    logic [23:0] din6;
    logic [3:0]  dout8, dout6;
    logic [2:0]  ch8, ch6;
    logic        v8, v6;

    logic [3:0]  ch_data [8];

    int checks   = 0;
    int failures = 0;

    mux_n1_scan #(.N_CH(8), .DATA_W(4)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .din        (din8),
        .sel        (sel),
        .en         (en),
        .mode       (mode),
        .out_ready  (out_ready),
        .dout       (dout8),
        .dout_ch    (ch8),
        .dout_valid (v8)
    );

    mux_n1_scan #(.N_CH(6), .DATA_W(4)) dut6 (
        .clk        (clk),
        .rst        (rst),
        .din        (din6),
        .sel        (sel),
        .en         (en),
        .mode       (mode),
        .out_ready  (out_ready),
        .dout       (dout6),
        .dout_ch    (ch6),
        .dout_valid (v6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] sel;
        logic       rdy;
        logic       ev;
        int         ech8;
        int         ed8;
        int         ech6;
        int         ed6;
    } vec_t;

    vec_t tbl [14];

    // Reference model state per instance (0: 8 channels, 1: 6 channels).
    int nch    [2] = '{8, 6};
    int m_run  [2];
    int m_valid[2];
    int m_data [2];
    int m_ch   [2];
    int m_scan [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic pack_din();
        for (int k = 0; k < 8; k++) din8[k*4 +: 4] = ch_data[k];
        for (int k = 0; k < 6; k++) din6[k*4 +: 4] = ch_data[k];
    endtask

    task automatic check_both(input string tag, input int ev, input int ec8, input int ed8,
                              input int ec6, input int ed6);
        check({tag, "_valid8"}, int'(v8), ev);
        check({tag, "_ch8"}, int'(ch8), ec8);
        check({tag, "_dout8"}, int'(dout8), ed8);
        check({tag, "_valid6"}, int'(v6), ev);
        check({tag, "_ch6"}, int'(ch6), ec6);
        check({tag, "_dout6"}, int'(dout6), ed6);
    endtask

    function automatic vec_t mk(input logic e, input logic m, input int s, input logic r,
                                input logic ev, input int c8, input int d8, input int c6, input int d6);
        vec_t v;
        v.en = e; v.mode = m; v.sel = 3'(s); v.rdy = r; v.ev = ev;
        v.ech8 = c8; v.ed8 = d8; v.ech6 = c6; v.ed6 = d6;
        return v;
    endfunction

    // One clock of the reference model, using the inputs currently driven.
    // A sample is taken while running with en high and the output slot free;
    // the block keeps running while en is high or a stalled sample remains.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int n;
            int idx;
            bit stalled;
            bit take;
            n = nch[d];
            if (rst) begin
                m_run[d] = 0; m_valid[d] = 0; m_data[d] = 0; m_ch[d] = 0; m_scan[d] = 0;
            end else begin
                stalled = (m_valid[d] != 0) && !out_ready;
                take    = (m_run[d] != 0) && en && !stalled;
                if (take) begin
                    if (SCAN_ON && mode) begin
                        idx       = m_scan[d];
                        m_scan[d] = (m_scan[d] + 1) % n;
                    end else begin
                        idx = (int'(sel) < n) ? int'(sel) : n - 1;
                    end
                    m_ch[d]    = idx;
                    m_data[d]  = int'(ch_data[idx]);
                    m_valid[d] = 1;
                end else if ((m_valid[d] != 0) && out_ready) begin
                    m_valid[d] = 0;
                end
                m_run[d] = (en || ((m_run[d] != 0) && stalled)) ? 1 : 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; out_ready = 1'b0; sel = 3'd0;
        for (int k = 0; k < 8; k++) ch_data[k] = 4'(k + 1);
        pack_din();

        // Reset state.
        tick();
        tick();
        check_both("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Directed table: channel k carries k+1.
        tbl[0]  = mk(1, 0, 5, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 5, 1, 1, 5, 6, 5, 6);
        tbl[2]  = mk(1, 0, 2, 0, 1, 5, 6, 5, 6);
        tbl[3]  = mk(1, 0, 2, 0, 1, 5, 6, 5, 6);
        tbl[4]  = mk(1, 0, 2, 1, 1, 2, 3, 2, 3);
        tbl[5]  = mk(1, 0, 7, 1, 1, 7, 8, 5, 6);
        tbl[6]  = mk(0, 0, 7, 0, 1, 7, 8, 5, 6);
        tbl[7]  = mk(0, 0, 7, 0, 1, 7, 8, 5, 6);
        tbl[8]  = mk(0, 0, 7, 1, 0, 7, 8, 5, 6);
        tbl[9]  = mk(1, 0, 0, 1, 0, 7, 8, 5, 6);
        tbl[10] = mk(1, 0, 0, 1, 1, 0, 1, 0, 1);
        tbl[11] = mk(1, 1, 3, 1, 1, SCAN_ON ? 0 : 3, SCAN_ON ? 1 : 4, SCAN_ON ? 0 : 3, SCAN_ON ? 1 : 4);
        tbl[12] = mk(1, 0, 4, 1, 1, 4, 5, 4, 5);
        tbl[13] = mk(0, 0, 4, 1, 0, 4, 5, 4, 5);
        for (int i = 0; i < 14; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; sel = tbl[i].sel; out_ready = tbl[i].rdy;
            tick();
            check_both($sformatf("vec%0d", i), int'(tbl[i].ev), tbl[i].ech8, tbl[i].ed8,
                       tbl[i].ech6, tbl[i].ed6);
        end

`ifdef MUX_N1_SCAN_EN
        // Scan sequence with wrap, then a 3-cycle stall at channel 2.
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b1; mode = 1'b1; out_ready = 1'b1; sel = 3'd6;
        tick();
        check("scan_start_valid", int'(v8), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_both($sformatf("scan%0d", i), 1, i % 8, (i % 8) + 1, i % 6, (i % 6) + 1);
        end
        tick();
        check_both("scan_pre_stall", 1, 2, 3, 4, 5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_both($sformatf("scan_stall%0d", i), 1, 2, 3, 4, 5);
        end
        out_ready = 1'b1;
        tick();
        check_both("scan_release", 1, 3, 4, 5, 6);
        en = 1'b0;
        tick();
        check("scan_stop_valid", int'(v8), 0);
`endif

        // Reset asserted while a sample is stalled.
        en = 1'b1; mode = 1'b0; sel = 3'd6; out_ready = 1'b1;
        tick();
        check_both("rs_idle_run", 0, int'(ch8), int'(dout8), int'(ch6), int'(dout6));
        tick();
        check_both("rs_load", 1, 6, 7, 5, 6);
        out_ready = 1'b0; sel = 3'd1;
        tick();
        check_both("rs_stall", 1, 6, 7, 5, 6);
        rst = 1'b1;
        tick();
        check_both("rs_reset", 0, 0, 0, 0, 0);
        rst = 1'b0; en = 1'b1; mode = 1'b1; sel = 3'd4; out_ready = 1'b1;
        tick();
        check_both("rs_after_idle", 0, 0, 0, 0, 0);
        tick();
        check_both("rs_first", 1, SCAN_ON ? 0 : 4, SCAN_ON ? 1 : 5, SCAN_ON ? 0 : 4, SCAN_ON ? 1 : 5);

        // Randomized traffic against the reference model.
        rst = 1'b1;
        model_step();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 49) == 0);
            en        = ($urandom_range(0, 9) != 0);
            mode      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            sel       = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) ch_data[k] = 4'($urandom_range(0, 15));
            pack_din();
            model_step();
            tick();
            check("rand_valid8", int'(v8), m_valid[0]);
            check("rand_ch8", int'(ch8), m_ch[0]);
            check("rand_dout8", int'(dout8), m_data[0]);
            check("rand_valid6", int'(v6), m_valid[1]);
            check("rand_ch6", int'(ch6), m_ch[1]);
            check("rand_dout6", int'(dout6), m_data[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
